alu_bist_ctrl: RTL and testbench

ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

---
 rtl/alu_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_ctrl.sv
// Built-in self-test sequencer for a 32-bit ALU: walks a fixed 21-entry vector/opcode
// table, compares the ALU response against an internal model and reports pass/fail.
module alu_bist_ctrl #(
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] test_a,
    output logic [31:0] test_b,
    input  logic [31:0] alu_result,
    input  logic        zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [4:0]  fail_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

    localparam logic [4:0] LAST_IDX = 5'd20;
    localparam logic [4:0] NO_FAIL  = 5'd31;
    localparam logic [2:0] LAST_OP  = 3'd6;

    state_t      state, next_state;
    logic [1:0]  vec_idx;
    logic [4:0]  test_idx;
    logic [2:0]  next_op;
    logic [1:0]  next_vec;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        mismatch;
    logic        load_first, load_next, record, finish;

    function automatic logic [31:0] rom_a(input logic [1:0] v);
        case (v)
            2'd0:    rom_a = 32'd10;
            2'd1:    rom_a = 32'hFFFF_FFFF;
            default: rom_a = 32'h8000_0000;
        endcase
    endfunction

    function automatic logic [31:0] rom_b(input logic [1:0] v);
        case (v)
            2'd0:    rom_b = 32'd15;
            2'd1:    rom_b = 32'h0000_0001;
            default: rom_b = 32'h0000_001F;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    model = a + b;
            4'd1:    model = a - b;
            4'd2:    model = a & b;
            4'd3:    model = a | b;
            4'd4:    model = a ^ b;
            4'd5:    model = a << b[4:0];
            4'd6:    model = a >> b[4:0];
            default: model = 32'd0;
        endcase
    endfunction

    // The model sees the registered operands, so it settles with the ALU during DRIVE.
    always_comb begin
        exp_result = model(alu_ctrl, test_a, test_b);
        exp_zero   = (exp_result == 32'd0);
        mismatch   = (alu_result != exp_result) || (zero != exp_zero);
        next_op    = (alu_ctrl[2:0] == LAST_OP) ? 3'd0 : alu_ctrl[2:0] + 3'd1;
        next_vec   = (alu_ctrl[2:0] == LAST_OP) ? vec_idx + 2'd1 : vec_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        record     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    next_state = DRIVE;
                end
            end
            DRIVE: next_state = CHECK;
            CHECK: begin
                record = mismatch;
                if (mismatch && STOP_ON_FAIL)  next_state = FINISH;
                else if (test_idx == LAST_IDX) next_state = FINISH;
                else begin
                    load_next  = 1'b1;
                    next_state = DRIVE;
                end
            end
            FINISH: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == DRIVE) || (state == CHECK);

    // Operands only change on a load, so they stay frozen across each DRIVE+CHECK pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctrl <= 4'd0;
            test_a   <= 32'd0;
            test_b   <= 32'd0;
            vec_idx  <= 2'd0;
            test_idx <= 5'd0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 8'd0;
            fail_idx <= NO_FAIL;
        end else begin
            if (load_first) begin
                alu_ctrl <= 4'd0;
                test_a   <= rom_a(2'd0);
                test_b   <= rom_b(2'd0);
                vec_idx  <= 2'd0;
                test_idx <= 5'd0;
                done     <= 1'b0;
                pass     <= 1'b0;
                err_cnt  <= 8'd0;
                fail_idx <= NO_FAIL;
            end
            if (load_next) begin
                alu_ctrl <= {1'b0, next_op};
                test_a   <= rom_a(next_vec);
                test_b   <= rom_b(next_vec);
                vec_idx  <= next_vec;
                test_idx <= test_idx + 5'd1;
            end
            if (record) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (fail_idx == NO_FAIL) fail_idx <= test_idx;
            end
            if (finish) begin
                done <= 1'b1;
                pass <= (err_cnt == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (stop-on-fail and run-all) share stimulus and
// each drives its own behavioural ALU, which can be given a SUB fault or a stuck zero flag.
module tb_alu_bist_ctrl;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    typedef struct {
        int done_cycle;
        bit pass;
        int err;
        int fidx;
    } outcome_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   fault_mode = 0;

    logic [3:0]  ctrl_s, ctrl_r;
    logic [31:0] a_s, b_s, a_r, b_r, res_s, res_r;
    logic        zero_s, zero_r;
    logic        busy_s, done_s, pass_s, busy_r, done_r, pass_r;
    logic [7:0]  err_s, err_r;
    logic [4:0]  fidx_s, fidx_r;

    int vectors = 0;
    int miscompares = 0;

    outcome_t sb_stop[$];
    outcome_t sb_run[$];
    vec_t     ops_q[$];

    always #5 clk = ~clk;

    // fault 1: SUB behaves as ADD; fault 2: zero flag stuck at 0
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input int fault);
        logic [31:0] r;
        logic        z;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = (fault == 1) ? a + b : a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        z = (fault == 2) ? 1'b0 : (r == 32'd0);
        return {z, r};
    endfunction

    always_comb {zero_s, res_s} = alu_model(ctrl_s, a_s, b_s, fault_mode);
    always_comb {zero_r, res_r} = alu_model(ctrl_r, a_r, b_r, fault_mode);

    alu_bist_ctrl #(.STOP_ON_FAIL(1'b1)) dut_stop (
        .clk(clk), .reset(reset), .start(start),
        .alu_ctrl(ctrl_s), .test_a(a_s), .test_b(b_s),
        .alu_result(res_s), .zero(zero_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s), .fail_idx(fidx_s)
    );

    alu_bist_ctrl #(.STOP_ON_FAIL(1'b0)) dut_run (
        .clk(clk), .reset(reset), .start(start),
        .alu_ctrl(ctrl_r), .test_a(a_r), .test_b(b_r),
        .alu_result(res_r), .zero(zero_r),
        .busy(busy_r), .done(done_r), .pass(pass_r), .err_cnt(err_r), .fail_idx(fidx_r)
    );

    function automatic vec_t vec_of(input int t);
        vec_t v;
        v.op = 4'(t % 7);
        case (t / 7)
            0:       begin v.a = 32'd10;        v.b = 32'd15;        end
            1:       begin v.a = 32'hFFFF_FFFF; v.b = 32'h0000_0001; end
            default: begin v.a = 32'h8000_0000; v.b = 32'h0000_001F; end
        endcase
        return v;
    endfunction

    function automatic outcome_t predict(input int fault, input bit stop);
        outcome_t o;
        vec_t     v;
        logic [32:0] good, seen;
        o.err = 0;
        o.fidx = 31;
        o.done_cycle = 43;
        for (int t = 0; t < 21; t++) begin
            v = vec_of(t);
            good = alu_model(v.op, v.a, v.b, 0);
            seen = alu_model(v.op, v.a, v.b, fault);
            if (good !== seen) begin
                o.err++;
                if (o.fidx == 31) o.fidx = t;
                if (stop) begin
                    o.done_cycle = 2 * t + 3;
                    break;
                end
            end
        end
        o.pass = (o.err == 0);
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ctrl"}, 64'(ctrl_r), 64'd0);
        checkOutput({tag, "_a"}, 64'(a_r), 64'd0);
        checkOutput({tag, "_b"}, 64'(b_r), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy_r), 64'd0);
        checkOutput({tag, "_done"}, 64'(done_r), 64'd0);
        checkOutput({tag, "_pass"}, 64'(pass_r), 64'd0);
        checkOutput({tag, "_err"}, 64'(err_r), 64'd0);
        checkOutput({tag, "_fidx"}, 64'(fidx_r), 64'd31);
        checkOutput({tag, "_stop_busy"}, 64'(busy_s), 64'd0);
        checkOutput({tag, "_stop_fidx"}, 64'(fidx_s), 64'd31);
    endtask

    // Called #1 after an edge; start is sampled on the next rising edge (cycle 0).
    task automatic applyStimulus(input int fault);
        outcome_t exp_s, exp_r;
        vec_t     exp_v, last_v;
        int       cyc, done_s_cyc, done_r_cyc;
        fault_mode = fault;
        ops_q.delete();
        sb_stop.push_back(predict(fault, 1'b1));
        sb_run.push_back(predict(fault, 1'b0));
        for (int t = 0; t < 21; t++) ops_q.push_back(vec_of(t));

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("busy_after_start", 64'(busy_r), 64'd1);
        checkOutput("done_cleared", 64'(done_r), 64'd0);
        exp_v = ops_q.pop_front();
        last_v = exp_v;
        checkOutput("op_t0", 64'(ctrl_r), 64'(exp_v.op));
        checkOutput("a_t0", 64'(a_r), 64'(exp_v.a));
        checkOutput("b_t0", 64'(b_r), 64'(exp_v.b));

        cyc = 0;
        done_s_cyc = -1;
        done_r_cyc = -1;
        while (cyc < 60 && !done_r) begin
            @(posedge clk);
            #1 cyc++;
            if (done_s && done_s_cyc < 0) done_s_cyc = cyc;
            if (done_r) done_r_cyc = cyc;
            if (cyc <= 40 && cyc % 2 == 0 && ops_q.size() > 0) begin
                exp_v = ops_q.pop_front();
                last_v = exp_v;
                checkOutput("op_seq", 64'(ctrl_r), 64'(exp_v.op));
                checkOutput("a_seq", 64'(a_r), 64'(exp_v.a));
                checkOutput("b_seq", 64'(b_r), 64'(exp_v.b));
            end else if (cyc < 41 && cyc % 2 == 1) begin
                checkOutput("ops_stable", 64'({ctrl_r, a_r, b_r} == last_v), 64'd1);
            end
        end
        checkOutput("run_done", 64'(done_r), 64'd1);

        exp_s = sb_stop.pop_front();
        exp_r = sb_run.pop_front();
        checkOutput("stop_done_cycle", 64'(done_s_cyc), 64'(exp_s.done_cycle));
        checkOutput("stop_pass", 64'(pass_s), 64'(exp_s.pass));
        checkOutput("stop_err", 64'(err_s), 64'(exp_s.err));
        checkOutput("stop_fidx", 64'(fidx_s), 64'(exp_s.fidx));
        checkOutput("stop_busy", 64'(busy_s), 64'd0);
        checkOutput("stop_done_held", 64'(done_s), 64'd1);
        checkOutput("run_done_cycle", 64'(done_r_cyc), 64'(exp_r.done_cycle));
        checkOutput("run_pass", 64'(pass_r), 64'(exp_r.pass));
        checkOutput("run_err", 64'(err_r), 64'(exp_r.err));
        checkOutput("run_fidx", 64'(fidx_r), 64'(exp_r.fidx));
        checkOutput("run_busy", 64'(busy_r), 64'd0);
    endtask

    initial begin
        $display("[TB] alu_bist_ctrl bench starting");
        repeat (3) @(posedge clk);
        #1 checkResetState("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 checkResetState("idle_after_reset");

        // clean ALU, then back-to-back runs issued while done is still high
        applyStimulus(0);
        applyStimulus(1);
        applyStimulus(2);

        // abort mid-run: an ignored start, then asynchronous reset at cycle 15
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("ignored_start_op", 64'(ctrl_r), 64'd5);
        checkOutput("ignored_start_a", 64'(a_r), 64'd10);
        checkOutput("ignored_start_busy", 64'(busy_r), 64'd1);
        checkOutput("ignored_start_err", 64'(err_r), 64'd0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1 checkResetState("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 checkOutput("no_done_after_abort", 64'(done_r), 64'd0);
        checkOutput("no_busy_after_abort", 64'(busy_r), 64'd0);

        applyStimulus(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
